sr_cmd_gen: RTL and testbench

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_cmd_gen.sv | 81 ++++++++
 tb/tb_sr_cmd_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear command generator for a downstream SR flip-flop: two synchronized,
// debounced button channels producing one-cycle s/r pulses, clear winning on a tie.
// Optional build macro SR_CMD_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_btn,
  input  logic       clr_btn,
  output logic       s,
  output logic       r,
  output logic       conflict
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // Channel 0 is set, channel 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    rise;

  assign raw  = {clr_btn, set_btn};
  assign rise = deb & ~deb_d;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would collapse the synchronizer into one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_d    <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      for (int ch = 0; ch < 2; ch++) cnt[ch] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int ch = 0; ch < 2; ch++) begin
        // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
        if (sync2[ch] != deb[ch]) begin
          if (cnt[ch] == CNT_LAST) begin
            deb[ch] <= ~deb[ch];
            cnt[ch] <= '0;
          end else begin
            cnt[ch] <= cnt[ch] + 1'b1;
          end
        end else begin
          cnt[ch] <= '0;
        end
      end
      // Clear wins a simultaneous rise so the flip-flop never sees s=r=1.
      s        <= rise[0] & ~rise[1];
      r        <= rise[1];
      conflict <= rise[0] & rise[1];
    end
  end

`ifdef SR_CMD_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: a cycle model of the debounce/pulse rules checked
// every cycle, plus directed scenarios with hand-computed pulse edges and a random soak.
module tb_sr_cmd_gen;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic clr_btn;
  logic s;
  logic r;
  logic conflict;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int conf_seen = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .set_btn      (set_btn),
    .clr_btn      (clr_btn),
    .s            (s),
    .r            (r),
    .conflict     (conflict)
`ifdef SR_CMD_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Model state: raw samples delayed two edges, a debounced level per channel,
  // the length of the current run of disagreeing samples, and a pending-rise flag.
  logic [1:0] m_sync1, m_sync2, m_deb, m_pend;
  int         m_run [2];
  logic       exp_s, exp_r, exp_c;
  int         exp_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic cb, input logic sb);
    if (rs) begin
      m_sync1 = '0; m_sync2 = '0; m_deb = '0; m_pend = '0;
      m_run[0] = 0; m_run[1] = 0;
      exp_s = 0; exp_r = 0; exp_c = 0; exp_cnt = 0;
    end else begin
      if (exp_c && exp_cnt < 255) exp_cnt++;
      exp_c = m_pend[0] && m_pend[1];
      exp_r = m_pend[1];
      exp_s = m_pend[0] && !m_pend[1];
      for (int ch = 0; ch < 2; ch++) begin
        m_pend[ch] = 1'b0;
        if (m_sync2[ch] != m_deb[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_deb[ch]  = ~m_deb[ch];
            m_run[ch]  = 0;
            m_pend[ch] = m_deb[ch];
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = {cb, sb};
    end
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare 1 time unit later.
  task automatic tick(input logic rs, input logic cb, input logic sb);
    reset = rs; clr_btn = cb; set_btn = sb;
    @(posedge clk);
    model_step(rs, cb, sb);
    #1;
    check("s", int'(s), int'(exp_s));
    check("r", int'(r), int'(exp_r));
    check("conflict", int'(conflict), int'(exp_c));
`ifdef SR_CMD_CONFLICT_CNT_EN
    check("conflict_cnt", int'(conflict_cnt), exp_cnt);
`endif
    if (conflict) conf_seen++;
  endtask

  // Directed scenario stimulus: returns {reset, clr_btn, set_btn} for edge e.
  function automatic logic [2:0] stim(input int kind, input int e);
    logic rs, cb, sb;
    rs = 1'b0; cb = 1'b0; sb = 1'b0;
    case (kind)
      0: sb = (e >= 10);
      1: cb = (e >= 10 && e <= 12);
      2: sb = (e >= 20) ? 1'b1 : ((e >= 10) ? ((e - 10) % 2 == 0) : 1'b0);
      3: begin sb = (e >= 10); cb = (e >= 10); end
      4: begin sb = (e >= 10); rs = (e == 13); end
      5: begin sb = 1'b1; rs = (e <= 3); end
      default: ;
    endcase
    return {rs, cb, sb};
  endfunction

  task automatic run_seq(input int kind, input int len,
                         output int first_s, output int n_s,
                         output int first_r, output int n_r, output int n_c);
    logic [2:0] v;
    first_s = 0; n_s = 0; first_r = 0; n_r = 0; n_c = 0;
    for (int e = 1; e <= len; e++) begin
      v = stim(kind, e);
      tick(v[2], v[1], v[0]);
      if (s) begin n_s++; if (first_s == 0) first_s = e; end
      if (r) begin n_r++; if (first_r == 0) first_r = e; end
      if (conflict) n_c++;
    end
  endtask

  task automatic clean_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  // s and r together would present the forbidden 11 code to the flip-flop.
  always @(negedge clk) begin
    if (s === 1'b1 && r === 1'b1) begin
      errors++;
      $display("FAIL s_and_r at %0t: got s=1 r=1 expected not both", $time);
    end
  end

  initial begin
    int fs, ns, fr, nr, nc;
    int hs, hc;
    logic ls, lc;

    reset = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    clean_reset();
    check("reset_s", int'(s), 0);
    check("reset_r", int'(r), 0);
    check("reset_conflict", int'(conflict), 0);

    // Held set first sampled at edge 10: pulse on edge 16 only.
    clean_reset();
    run_seq(0, 30, fs, ns, fr, nr, nc);
    check("held_set_edge", fs, 16);
    check("held_set_count", ns, 1);
    check("held_set_no_r", nr, 0);
    check("held_set_no_conflict", nc, 0);

    // Three-cycle clear glitch is rejected.
    clean_reset();
    run_seq(1, 40, fs, ns, fr, nr, nc);
    check("glitch_no_r", nr, 0);
    check("glitch_no_s", ns, 0);

    // Bounce for 10 cycles, stable from edge 20: pulse 6 edges later.
    clean_reset();
    run_seq(2, 40, fs, ns, fr, nr, nc);
    check("bounce_edge", fs, 26);
    check("bounce_count", ns, 1);

    // Simultaneous rise: clear wins and conflict flags once.
    clean_reset();
    run_seq(3, 30, fs, ns, fr, nr, nc);
    check("tie_r_edge", fr, 16);
    check("tie_r_count", nr, 1);
    check("tie_no_s", ns, 0);
    check("tie_conflict_count", nc, 1);
`ifdef SR_CMD_CONFLICT_CNT_EN
    check("tie_conflict_cnt", int'(conflict_cnt), 1);
`endif

    // Reset at edge 13 restarts debouncing: pulse on edge 20.
    clean_reset();
    run_seq(4, 30, fs, ns, fr, nr, nc);
    check("midreset_edge", fs, 20);
    check("midreset_count", ns, 1);

    // Input held through reset: first post-reset sample at edge 4, pulse on edge 10.
    run_seq(5, 25, fs, ns, fr, nr, nc);
    check("held_through_reset_edge", fs, 10);
    check("held_through_reset_count", ns, 1);

    // 256 conflict events saturate the counter at 255.
    clean_reset();
    conf_seen = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
    end
    check("conflict_events", conf_seen, 256);
`ifdef SR_CMD_CONFLICT_CNT_EN
    check("conflict_cnt_saturated", int'(conflict_cnt), 255);
`endif

    // Random bouncing on both inputs with occasional reset.
    clean_reset();
    hs = 0; hc = 0; ls = 1'b0; lc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (hs == 0) begin ls = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 7); end
      if (hc == 0) begin lc = 1'($urandom_range(0, 1)); hc = $urandom_range(1, 7); end
      hs--; hc--;
      tick(($urandom_range(0, 499) == 0), lc, ls);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
